// File: rtl/seven_segment_seconds.sv
// Free-running decimal digit counter that steps once every `cmp` clocks and
// drives the current digit as an active-high 7-segment pattern (bit0=a .. bit6=g).
module seven_segment_seconds #(
  parameter int unsigned             CNT_WIDTH       = 24,
  parameter logic [CNT_WIDTH-1:0]    DEFAULT_COMPARE = CNT_WIDTH'(1000)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 compare_we,
  input  logic [CNT_WIDTH-1:0] compare_in,
  output logic [6:0]           seg,
  output logic [6:0]           seg_oeb,
  output logic [3:0]           digit
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
  logic [DIGIT_W-1:0]   d_q, d_d;
  logic [CNT_WIDTH-1:0] eff_cmp;
  logic                 wrap;

  // A compare value of zero behaves as one, i.e. step every cycle.
  assign eff_cmp = (cmp_q == '0) ? CNT_WIDTH'(1) : cmp_q;
  assign wrap    = (cnt_q == (eff_cmp - CNT_WIDTH'(1)));

  // Next-state: a load clears the counter so a smaller compare cannot be overrun.
  always_comb begin
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    d_d   = d_q;
    if (compare_we) begin
      cmp_d = compare_in;
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      d_d   = (d_q == DIGIT_W'(9)) ? '0 : d_q + DIGIT_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      cmp_q <= DEFAULT_COMPARE;
      d_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      d_q   <= d_d;
    end
  end

  // Segment decode; 6 has no top bar and 9 has no bottom bar.
  always_comb begin
    seg = '0;
    case (d_q)
      4'd0:    seg = SEG_W'(7'b0111111);
      4'd1:    seg = SEG_W'(7'b0000110);
      4'd2:    seg = SEG_W'(7'b1011011);
      4'd3:    seg = SEG_W'(7'b1001111);
      4'd4:    seg = SEG_W'(7'b1100110);
      4'd5:    seg = SEG_W'(7'b1101101);
      4'd6:    seg = SEG_W'(7'b1111100);
      4'd7:    seg = SEG_W'(7'b0000111);
      4'd8:    seg = SEG_W'(7'b1111111);
      4'd9:    seg = SEG_W'(7'b1100111);
      default: seg = '0;
    endcase
  end

  assign digit   = d_q;
  assign seg_oeb = '0;

endmodule

// File: tb/tb_seven_segment_seconds.sv
// Directed bench for seven_segment_seconds: reset, full digit sweep, compare
// loads (including zero) and reset mid-count, with hand-computed expectations.
module tb_seven_segment_seconds;

  localparam int unsigned CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [CW-1:0] cin;
  logic [6:0]    seg;
  logic [6:0]    seg_oeb;
  logic [3:0]    digit;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_seconds dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .compare_we (we),
    .compare_in (cin),
    .seg        (seg),
    .seg_oeb    (seg_oeb),
    .digit      (digit)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111100;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the falling edge for sampling/driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_digit(input string tag, input int d);
    check({tag, " digit"}, 32'(digit), 32'(d));
    check({tag, " seg"},   32'(seg),   32'(exp_seg(d)));
  endtask

  initial begin
    rst = 1'b1;
    we  = 1'b0;
    cin = '0;
    @(negedge clk);
    check("oeb_in_reset", 32'(seg_oeb), 32'd0);
    tick(3);
    check_digit("reset", 0);
    check("oeb_after_reset", 32'(seg_oeb), 32'd0);

    // Default compare of 1000: first step on the 1000th edge after release.
    rst = 1'b0;
    tick(999);
    check_digit("hold_999", 0);
    tick(1);
    check_digit("step_1000", 1);
    for (int k = 2; k <= 9; k++) begin
      tick(1000);
      check_digit($sformatf("sweep_%0d", k), k);
    end
    tick(1000);
    check_digit("wrap_10000", 0);

    // Load 5 mid-count at digit 3; the load must clear the running count.
    tick(3400);
    check_digit("pre_load", 3);
    we = 1'b1; cin = CW'(5);
    tick(1);
    we = 1'b0;
    check_digit("load_cycle", 3);
    tick(4);
    check_digit("cmp5_hold", 3);
    tick(1);
    check_digit("cmp5_step4", 4);
    tick(4);
    check_digit("cmp5_hold4", 4);
    tick(1);
    check_digit("cmp5_step5", 5);

    // Compare zero behaves as one: step every clock, full turn in 10.
    we = 1'b1; cin = '0;
    tick(1);
    we = 1'b0;
    check_digit("cmp0_load", 5);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check_digit($sformatf("cmp0_%0d", i), (5 + i) % 10);
    end

    // Restore 1000, run to digit 7 mid-count, then reset with a competing load.
    we = 1'b1; cin = CW'(1000);
    tick(1);
    we = 1'b0;
    tick(2500);
    check_digit("pre_reset", 7);
    rst = 1'b1; we = 1'b1; cin = CW'(3);
    tick(1);
    rst = 1'b0; we = 1'b0;
    check_digit("mid_reset", 0);
    check("oeb_final", 32'(seg_oeb), 32'd0);
    tick(999);
    check_digit("post_reset_hold", 0);
    tick(1);
    check_digit("post_reset_step", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
